// File: rtl/execute_stage_pkg.sv
// ============================================================================
// Module : execute_stage_pkg
// Brief  : Shared opcode/select constants, width defaults and FSM state type
//          for the execute stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package execute_stage_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_W_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_IMMI = 2'b01;
  localparam logic [1:0] SRC2_IMMS = 2'b10;
  localparam logic [1:0] SRC2_FOUR = 2'b11;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } ex_state_e;

endpackage

`default_nettype wire

// File: rtl/execute_stage_alu.sv
// ============================================================================
// Module : alu
// Brief  : Combinational ALU with a zero flag used for branch resolution.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu
  import execute_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module : execute_stage
// Brief  : ID/EX consumer: ALU execute, branch resolve/redirect, wrong-path
//          squash and EX/MEM register. Optional EX_PERF_EN adds counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_W      = REG_W_DEF,
  parameter int KILL_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [2:0]       ALU_CONTROL,
  input  logic [1:0]       ALU_SRC2,
  input  logic             BRN_COND,
  input  logic             MEM_WE,
  input  logic             DE_WE,
  input  logic             MEM_REG,
  input  logic [XLEN-1:0]  D1,
  input  logic [XLEN-1:0]  D2,
  input  logic [24:0]      Imm,
  input  logic [XLEN-1:0]  PC_EX,
  input  logic             mem_stall,
  output logic             stall_out,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target,
  output logic [XLEN-1:0]  ALU_RES,
  output logic [XLEN-1:0]  WDATA,
  output logic [REG_W-1:0] RD,
  output logic             MEM_WE_M,
  output logic             DE_WE_M,
  output logic             MEM_REG_M,
  output logic             valid_m
`ifdef EX_PERF_EN
  ,
  output logic [31:0]      perf_exec,
  output logic [31:0]      perf_squash,
  output logic [31:0]      perf_br
`endif
);

  localparam int CNT_W = 3;

  logic [XLEN-1:0]  imm_i, imm_s, imm_b, op2, alu_res;
  logic             alu_zero, accept, squash, taken;
  logic             unused_imm;

  ex_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             br_taken_q, valid_m_q, mem_we_q, de_we_q, mem_reg_q;
  logic [XLEN-1:0]  br_target_q, alu_res_q, wdata_q;
  logic [REG_W-1:0] rd_q;

  assign imm_i = {{(XLEN-12){Imm[24]}}, Imm[24:13]};
  assign imm_s = {{(XLEN-12){Imm[24]}}, Imm[24:18], Imm[4:0]};
  assign imm_b = {{(XLEN-13){Imm[24]}}, Imm[24], Imm[0], Imm[23:18], Imm[4:1], 1'b0};
  assign unused_imm = ^Imm[12:5];

  always_comb begin
    op2 = D2;
    case (ALU_SRC2)
      SRC2_REG:  op2 = D2;
      SRC2_IMMI: op2 = imm_i;
      SRC2_IMMS: op2 = imm_s;
      SRC2_FOUR: op2 = XLEN'(4);
      default:   op2 = D2;
    endcase
  end

  alu #(.XLEN(XLEN)) u_alu (
    .op     (ALU_CONTROL),
    .a      (D1),
    .b      (op2),
    .result (alu_res),
    .zero   (alu_zero)
  );

  assign accept    = valid_in & ~mem_stall;
  assign squash    = (state_q == ST_KILL);
  assign taken     = accept & ~squash & BRN_COND & alu_zero;
  assign stall_out = mem_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      case (state_q)
        ST_RUN: begin
          if (taken) begin
            cnt_d   = CNT_W'(KILL_DEPTH);
            state_d = ST_KILL;
          end
        end
        ST_KILL: begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      alu_res_q   <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      valid_m_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      de_we_q     <= 1'b0;
      mem_reg_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      br_taken_q <= taken;
      if (taken) br_target_q <= PC_EX + imm_b;
      // Data fields load even on squashed bundles; only qualifiers are gated.
      if (accept) begin
        alu_res_q <= alu_res;
        wdata_q   <= D2;
        rd_q      <= Imm[REG_W-1:0];
        valid_m_q <= ~squash;
        mem_we_q  <= MEM_WE & ~squash;
        de_we_q   <= DE_WE & ~squash;
        mem_reg_q <= MEM_REG;
      end else if (!mem_stall) begin
        valid_m_q <= 1'b0;
        mem_we_q  <= 1'b0;
        de_we_q   <= 1'b0;
      end
    end
  end

  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign ALU_RES   = alu_res_q;
  assign WDATA     = wdata_q;
  assign RD        = rd_q;
  assign MEM_WE_M  = mem_we_q;
  assign DE_WE_M   = de_we_q;
  assign MEM_REG_M = mem_reg_q;
  assign valid_m   = valid_m_q;

`ifdef EX_PERF_EN
  logic [31:0] perf_exec_q, perf_squash_q, perf_br_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_exec_q   <= '0;
      perf_squash_q <= '0;
      perf_br_q     <= '0;
    end else begin
      if (accept & ~squash) perf_exec_q   <= perf_exec_q + 32'd1;
      if (accept & squash)  perf_squash_q <= perf_squash_q + 32'd1;
      if (taken)            perf_br_q     <= perf_br_q + 32'd1;
    end
  end

  assign perf_exec   = perf_exec_q;
  assign perf_squash = perf_squash_q;
  assign perf_br     = perf_br_q;
`endif

endmodule

`default_nettype wire
